uart_tx_param: RTL and testbench

Parametrised UART transmitter, the next-generation replacement for the fixed 8N1 transmitter. It is configurable in data width, parity and stop-bit count, and accepts bytes through a valid/ready handshake into an internal FIFO. Frames are sent back-to-back with no idle gap. The block sits between any byte-producing logic and the serial `uart_tx_out` pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_param.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and baud-count helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } uart_state_e;

    // Clocks per bit; truncating division so the receiver derives the identical period.
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; writes to a full FIFO and reads from an empty one are
// dropped.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered input, configurable data width, parity and stop
// bits, frames sent back-to-back with no idle gap.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BPS          = 9_600,
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_reset_n,
    input  logic                          uart_tx_valid,
    input  logic [DATA_WIDTH-1:0]         uart_tx_data,
    output logic                          uart_tx_ready,
    output logic                          uart_tx_out,
    output logic                          uart_tx_done,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(SYS_CLK_FREQ, BPS);
    localparam int unsigned BAUD_W       = $clog2(BAUD_CNT_MAX);
    localparam int unsigned IDX_W        = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [IDX_W-1:0]  DataLast = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  StopLast = IDX_W'(STOP_BITS - 1);

    if (BAUD_CNT_MAX < 2) begin : g_bad_baud
        $error("SYS_CLK_FREQ / BPS must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("DATA_WIDTH must be in 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .wr_en       (uart_tx_valid),
        .wr_data     (uart_tx_data),
        .full        (fifo_full),
        .rd_en       (fifo_pop),
        .rd_data     (fifo_rd_data),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    assign uart_tx_ready = !fifo_full;

    uart_state_e           state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic                  bit_end;
    logic                  start_frame;

    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d     = state_q;
        baud_d      = bit_end ? '0 : baud_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d      = '0;
                tx_d        = 1'b1;
                start_frame = !fifo_empty;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == DataLast) begin
                        idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = StPar;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StPar: begin
                if (bit_end) begin
                    state_d = StStop;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == StopLast) begin
                        done_d      = 1'b1;
                        state_d     = StIdle;
                        start_frame = !fifo_empty;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared by IDLE and the end of STOP so a queued word starts with zero idle time.
        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            par_d    = (^fifo_rd_data) ^ (PARITY == PAR_ODD);
            tx_d     = 1'b0;
            baud_d   = '0;
            state_d  = StStart;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign uart_tx_out  = tx_q;
    assign uart_tx_done = done_q;
    assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks/bit.
module tb_uart_tx_param;

    localparam int BAUD = 10;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    typedef struct {
        int          d;
        logic [7:0]  word;
        logic [15:0] bits;
        int          n;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] valid;
    logic [7:0] data_v [4];
    logic [3:0] tx, done, busy, ready;
    logic [2:0] cnt [4];

    int cfg_dw   [4] = '{8, 8, 8, 7};
    int cfg_par  [4] = '{0, 2, 1, 0};
    int cfg_stop [4] = '{1, 1, 1, 2};

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_q [$];

    uart_tx_param #(
        .DATA_WIDTH (8), .BPS (5_000_000), .SYS_CLK_FREQ (50_000_000),
        .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut_8n1 (
        .sys_clk (clk), .sys_reset_n (rst_n), .uart_tx_valid (valid[0]),
        .uart_tx_data (data_v[0]), .uart_tx_ready (ready[0]), .uart_tx_out (tx[0]),
        .uart_tx_done (done[0]), .uart_tx_busy (busy[0]), .fifo_count (cnt[0])
    );

    uart_tx_param #(
        .DATA_WIDTH (8), .BPS (5_000_000), .SYS_CLK_FREQ (50_000_000),
        .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut_8e1 (
        .sys_clk (clk), .sys_reset_n (rst_n), .uart_tx_valid (valid[1]),
        .uart_tx_data (data_v[1]), .uart_tx_ready (ready[1]), .uart_tx_out (tx[1]),
        .uart_tx_done (done[1]), .uart_tx_busy (busy[1]), .fifo_count (cnt[1])
    );

    uart_tx_param #(
        .DATA_WIDTH (8), .BPS (5_000_000), .SYS_CLK_FREQ (50_000_000),
        .PARITY (1), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut_8o1 (
        .sys_clk (clk), .sys_reset_n (rst_n), .uart_tx_valid (valid[2]),
        .uart_tx_data (data_v[2]), .uart_tx_ready (ready[2]), .uart_tx_out (tx[2]),
        .uart_tx_done (done[2]), .uart_tx_busy (busy[2]), .fifo_count (cnt[2])
    );

    uart_tx_param #(
        .DATA_WIDTH (7), .BPS (5_000_000), .SYS_CLK_FREQ (50_000_000),
        .PARITY (0), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_dut_7n2 (
        .sys_clk (clk), .sys_reset_n (rst_n), .uart_tx_valid (valid[3]),
        .uart_tx_data (data_v[3][6:0]), .uart_tx_ready (ready[3]), .uart_tx_out (tx[3]),
        .uart_tx_done (done[3]), .uart_tx_busy (busy[3]), .fifo_count (cnt[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference frame: list of line levels built straight from the frame-format rules.
    function automatic frame_t model_frame(input int d, input logic [7:0] word);
        frame_t f;
        bit     q [$];
        int     ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < cfg_dw[d]; i++) begin
            q.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (cfg_par[d] == 2) q.push_back((ones % 2) == 1);
        if (cfg_par[d] == 1) q.push_back((ones % 2) == 0);
        for (int i = 0; i < cfg_stop[d]; i++) q.push_back(1'b1);
        f.bits = '0;
        f.n    = q.size();
        for (int i = 0; i < f.n; i++) f.bits[i] = q[i];
        return f;
    endfunction

    // Waits (bounded) for the falling start edge, then checks k back-to-back frames cycle by cycle.
    task automatic check_frames(input int d, input int k, input int max_wait);
        int          w;
        int          bad;
        int          early;
        logic [15:0] got;
        frame_t      f;
        w = 0;
        @(negedge clk);
        while (tx[d] !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("start_edge", int'(tx[d]), 0);
        for (int n = 0; n < k; n++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL exp_queue: got no expected frame for frame %0d, expected one", n);
                return;
            end
            f     = exp_q.pop_front();
            got   = '0;
            bad   = 0;
            early = 0;
            for (int j = 0; j < f.n * BAUD; j++) begin
                if (j > 0) @(negedge clk);
                if (j % BAUD == BAUD / 2) got[j / BAUD] = tx[d];
                if (tx[d] !== f.bits[j / BAUD]) bad++;
                if (j > 0 && done[d] !== 1'b0) early++;
            end
            chk("frame_bits", int'(got), int'(f.bits));
            chk("bit_timing", bad, 0);
            chk("done_early", early, 0);
            @(negedge clk);
            chk("done_pulse", int'(done[d]), 1);
            if (n < k - 1) begin
                chk("busy_across", int'(busy[d]), 1);
            end else begin
                chk("line_idle", int'(tx[d]), 1);
                chk("busy_clear", int'(busy[d]), 0);
                @(negedge clk);
                chk("done_single", int'(done[d]), 0);
            end
        end
    endtask

    task automatic send_one(input int d, input logic [7:0] word);
        @(negedge clk);
        chk("ready_idle", int'(ready[d]), 1);
        valid[d]  = 1'b1;
        data_v[d] = word;
        @(negedge clk);
        valid[d] = 1'b0;
        chk("count_after_write", int'(cnt[d]), 1);
        chk("line_before_pop", int'(tx[d]), 1);
        check_frames(d, 1, 0);
    endtask

    vec_t       tbl [4];
    logic [7:0] fw  [6];
    logic [7:0] wa;
    logic [7:0] w;
    int         stray;

    initial begin
        // Hand-derived line sequences, first bit on the line in bit 0.
        tbl[0] = '{d: 0, word: 8'h55, bits: 16'h02AA, n: 10};
        tbl[1] = '{d: 1, word: 8'h07, bits: 16'h060E, n: 11};
        tbl[2] = '{d: 2, word: 8'h07, bits: 16'h040E, n: 11};
        tbl[3] = '{d: 3, word: 8'h41, bits: 16'h0382, n: 10};

        rst_n = 1'b0;
        valid = '0;
        for (int i = 0; i < 4; i++) data_v[i] = '0;
        #23;
        for (int d = 0; d < 4; d++) begin
            chk("reset_tx", int'(tx[d]), 1);
            chk("reset_ready", int'(ready[d]), 1);
            chk("reset_done", int'(done[d]), 0);
            chk("reset_busy", int'(busy[d]), 0);
            chk("reset_count", int'(cnt[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            exp_q.push_back('{bits: tbl[t].bits, n: tbl[t].n});
            send_one(tbl[t].d, tbl[t].word);
        end

        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 3; r++) begin
                w = 8'($urandom_range(0, 255));
                if (cfg_dw[d] == 7) w[7] = 1'b0;
                exp_q.push_back(model_frame(d, w));
                send_one(d, w);
            end
        end

        // FIFO fill: six consecutive valid cycles; the sixth must wait for ready.
        for (int i = 0; i < 6; i++) fw[i] = 8'($urandom_range(0, 255));
        fork
            begin : fill_drv
                int   i;
                int   guard;
                logic first6;
                logic acc;
                i      = 0;
                guard  = 0;
                first6 = 1'b1;
                @(negedge clk);
                valid[0]  = 1'b1;
                data_v[0] = fw[0];
                while (i < 6 && guard < 400) begin
                    if (i == 5 && first6) begin
                        chk("ready_low_when_full", int'(ready[0]), 0);
                        chk("count_full", int'(cnt[0]), 4);
                        first6 = 1'b0;
                    end else if (i < 5) begin
                        chk("ready_fill", int'(ready[0]), 1);
                    end
                    acc = ready[0];
                    @(negedge clk);
                    guard++;
                    if (acc) begin
                        exp_q.push_back(model_frame(0, fw[i]));
                        i++;
                        if (i < 6) data_v[0] = fw[i];
                        else valid[0] = 1'b0;
                    end
                end
                valid[0] = 1'b0;
                chk("fill_accepted", i, 6);
            end
            check_frames(0, 6, 2);
        join

        // Reset during data bit 3 of the first of two queued frames.
        wa = 8'h96;
        @(negedge clk);
        valid[0]  = 1'b1;
        data_v[0] = wa;
        @(negedge clk);
        data_v[0] = 8'h3C;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("rst_fall_seen", int'(tx[0]), 0);
        repeat (45) @(negedge clk);
        chk("rst_pre_bit3", int'(tx[0]), int'(wa[3]));
        chk("rst_pre_count", int'(cnt[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", int'(tx[0]), 1);
        chk("rst_async_count", int'(cnt[0]), 0);
        chk("rst_async_busy", int'(busy[0]), 0);
        chk("rst_async_ready", int'(ready[0]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (150) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) stray++;
        end
        chk("rst_no_done_no_frame", stray, 0);
        exp_q.push_back(model_frame(0, 8'hA3));
        send_one(0, 8'hA3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
